// File: rtl/bus_arbiter4_if.sv
// bus_arbiter4_if: request, source data, grant and shared-bus signals of the 4-way arbiter.
`default_nettype none

interface bus_arbiter4_if;
  logic [3:0]  req;
  logic [31:0] C0;
  logic [31:0] C1;
  logic [31:0] C2;
  logic [31:0] C3;
  logic        iReady;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] oZ;
  logic        oValid;

  modport master (
    output req, C0, C1, C2, C3, iReady,
    input  gnt, sel, oZ, oValid
  );

  modport slave (
    input  req, C0, C1, C2, C3, iReady,
    output gnt, sel, oZ, oValid
  );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter4.sv
// +---------------------------------------------------------------------------+
// | bus_arbiter4: 4-source round-robin bus arbiter with bounded bursts.       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module bus_arbiter4 #(
  parameter int BURST = 4
) (
  input  wire            clk,
  input  wire            rst_n,
  bus_arbiter4_if.slave  bus
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  req_rot;
  logic [1:0]  offset;
  logic [1:0]  winner;
  logic        owner_req;
  logic        beat_acc;
  logic [3:0]  gnt;
  logic        ovalid;
  logic [31:0] oz;

  // Rotate requests so bit 0 is the source at ptr; lowest set bit wins.
  always_comb begin
    req_rot = bus.req;
    case (ptr_q)
      2'd1:    req_rot = {bus.req[0],   bus.req[3:1]};
      2'd2:    req_rot = {bus.req[1:0], bus.req[3:2]};
      2'd3:    req_rot = {bus.req[2:0], bus.req[3]};
      default: req_rot = bus.req;
    endcase
  end

  always_comb begin
    offset = 2'd3;
    if (req_rot[0])      offset = 2'd0;
    else if (req_rot[1]) offset = 2'd1;
    else if (req_rot[2]) offset = 2'd2;
  end

  assign winner    = ptr_q + offset;
  assign owner_req = bus.req[sel_q];
  assign beat_acc  = (state_q == BUSY) && owner_req && bus.iReady;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = BUSY;
          sel_d   = winner;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // A dropped owner request releases without taking a beat.
        if (!owner_req || (beat_acc && (cnt_q == LAST_BEAT))) begin
          state_d = IDLE;
          cnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end else if (beat_acc) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus outputs decode from registered state so reset clears them at once.
  always_comb begin
    gnt    = 4'b0000;
    ovalid = 1'b0;
    oz     = 32'h0;
    if (state_q == BUSY) begin
      gnt[sel_q] = 1'b1;
      ovalid     = owner_req;
      case (sel_q)
        2'd0:    oz = bus.C0;
        2'd1:    oz = bus.C1;
        2'd2:    oz = bus.C2;
        default: oz = bus.C3;
      endcase
    end
  end

  assign bus.gnt    = gnt;
  assign bus.sel    = sel_q;
  assign bus.oValid = ovalid;
  assign bus.oZ     = oz;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed and random stimulus checked against a round-robin reference model.
`default_nettype none

module tb_bus_arbiter4;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] c_val [4];

  int errors = 0;
  int checks = 0;

  bus_arbiter4_if bus ();

  assign bus.C0 = c_val[0];
  assign bus.C1 = c_val[1];
  assign bus.C2 = c_val[2];
  assign bus.C3 = c_val[3];

  bus_arbiter4 #(.BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_index(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference model: owner index (-1 = none), round-robin start, beats taken.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_beats = 0;
  logic [1:0] m_sel   = 2'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_sel   = 2'd0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (m_owner < 0 && bus.req[idx]) m_owner = idx;
      end
      if (m_owner >= 0) begin
        m_beats = 0;
        m_sel   = m_owner[1:0];
      end
    end else if (!bus.req[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (bus.iReady) begin
      m_beats++;
      if (m_beats == BURST) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  end

  int         grant_q[$];
  int         beat_q[$];
  int         cur_beats = 0;
  logic [3:0] prev_gnt  = 4'b0;
  logic [3:0] prev_req  = 4'b0;
  int         waits[4]  = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt  = 4'b0;
      prev_req  = 4'b0;
      cur_beats = 0;
      for (int i = 0; i < 4; i++) waits[i] = 0;
    end else begin
      logic [3:0]  e_gnt;
      logic        e_valid;
      logic [31:0] e_oz;
      e_gnt   = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
      e_valid = (m_owner >= 0) && bus.req[m_owner];
      e_oz    = (m_owner < 0) ? 32'h0 : c_val[m_owner];
      chk("gnt", 32'(bus.gnt), 32'(e_gnt));
      chk("sel", 32'(bus.sel), 32'(m_sel));
      chk("oValid", 32'(bus.oValid), 32'(e_valid));
      chk("oZ", bus.oZ, e_oz);
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      if (bus.gnt != 4'b0) chk("sel_vs_gnt", 32'(oh_index(bus.gnt)), 32'(bus.sel));

      if (bus.gnt != 4'b0 && prev_gnt == 4'b0) begin
        int w;
        int worst;
        w = oh_index(bus.gnt);
        grant_q.push_back(w);
        worst = 0;
        for (int i = 0; i < 4; i++) begin
          if (i == w) waits[i] = 0;
          else if (prev_req[i]) waits[i]++;
          if (waits[i] > worst) worst = waits[i];
        end
        chk("starve_max_le3", 32'(worst <= 3), 32'd1);
      end
      if (bus.gnt != 4'b0 && bus.oValid && bus.iReady) cur_beats++;
      if (bus.gnt == 4'b0 && prev_gnt != 4'b0) begin
        beat_q.push_back(cur_beats);
        cur_beats = 0;
      end
      for (int i = 0; i < 4; i++) if (!bus.req[i]) waits[i] = 0;
      prev_gnt = bus.gnt;
      prev_req = bus.req;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_oValid", 32'(bus.oValid), 32'd0);
    chk("rst_oZ", bus.oZ, 32'd0);
    tick(2);
    rst_n = 1'b1;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req    = 4'b0;
    bus.iReady = 1'b0;
    c_val      = '{32'hC000_0A00, 32'hC111_1B11, 32'hC222_2C22, 32'hC333_3D33};
    #1;
    do_reset();

    // All request, consumer always ready: 0,1,2,3,0 with full bursts.
    grant_q.delete();
    beat_q.delete();
    bus.req    = 4'b1111;
    bus.iReady = 1'b1;
    tick(25);
    bus.req = 4'b0;
    tick(2);
    for (int k = 0; k < 5; k++)
      chk("grant_order", (k < grant_q.size()) ? 32'(grant_q[k]) : 32'hDEAD, 32'(exp_order[k]));
    for (int k = 0; k < 4; k++)
      chk("burst_beats", (k < beat_q.size()) ? 32'(beat_q[k]) : 32'hDEAD, 32'(BURST));

    // Single requester stalled by the consumer, then drained.
    do_reset();
    bus.req    = 4'b0100;
    bus.iReady = 1'b0;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_gnt", 32'(bus.gnt), 32'h4);
      chk("stall_oValid", 32'(bus.oValid), 32'd1);
      chk("stall_oZ", bus.oZ, 32'hC222_2C22);
      tick(1);
    end
    bus.iReady = 1'b1;
    tick(3);
    chk("drain_gnt_after3", 32'(bus.gnt), 32'h4);
    tick(1);
    chk("drain_gnt_after4", 32'(bus.gnt), 32'h0);
    bus.req = 4'b0;
    tick(1);

    // Owner 1 drops after two beats; source 3 follows one idle cycle later.
    do_reset();
    bus.req    = 4'b1010;
    bus.iReady = 1'b1;
    tick(1);
    chk("early_gnt1", 32'(bus.gnt), 32'h2);
    tick(2);
    bus.req = 4'b1000;
    tick(1);
    chk("early_release", 32'(bus.gnt), 32'h0);
    tick(1);
    chk("early_gnt3", 32'(bus.gnt), 32'h8);

    // Owner 3 releases; pointer wraps so source 0 beats source 3.
    bus.req = 4'b0001;
    tick(1);
    chk("wrap_release", 32'(bus.gnt), 32'h0);
    bus.req = 4'b1001;
    tick(1);
    chk("wrap_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0;
    tick(2);

    // Asynchronous reset in the middle of beat 2.
    do_reset();
    bus.req    = 4'b1111;
    bus.iReady = 1'b1;
    tick(2);
    chk("mid_valid_before", 32'(bus.oValid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_oValid", 32'(bus.oValid), 32'd0);
    chk("mid_rst_oZ", bus.oZ, 32'd0);
    chk("mid_rst_sel", 32'(bus.sel), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0;
    tick(6);

    // Random traffic; requests mostly held so fairness is exercised.
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
        c_val[i] = $urandom;
      end
      bus.iReady = ($urandom_range(3) != 0);
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
